pci_target_mem: RTL and testbench

PCI_TARGET_MEM -- requirements
Module: pci_target_mem

---
 rtl/pci_target_mem.sv | 164 ++++++++++++++++
 tb/tb_pci_target_mem.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pci_target_mem.sv
// rtl/pci_target_mem.sv - PCI target claiming a small word-addressed memory window
module pci_target_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0200,
  parameter int          ADDR_BITS   = 4,
  parameter int          MEM_SPACE   = 0,
  parameter int          WAIT_STATES = 0
) (
  input  logic        PCI_CLK,
  input  logic        PCI_RSTn,
  input  logic        PCI_FRAMEn,
  input  logic        PCI_IRDYn,
  input  logic [3:0]  PCI_CBE,
  inout  wire  [31:0] PCI_AD,
  output logic        PCI_TRDYn,
  output logic        PCI_DEVSELn,
  output logic        PCI_STOPn
);

  localparam int                   DEPTH    = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST     = '1;
  localparam logic [ADDR_BITS-1:0] ONE      = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam bit                   HAS_WAIT = (WAIT_STATES != 0);
  localparam logic [1:0]           WS_LAST  = 2'(HAS_WAIT ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {IDLE, BUSY, TURN, WAIT, DATA, STOPPING, RELEASE} state_t;

  state_t               state, state_d;
  logic [ADDR_BITS-1:0] ptr, ptr_d;
  logic [1:0]           wcnt, wcnt_d;
  logic                 is_read, is_read_d;
  logic                 bus_idle;
  logic                 cmd_rd, cmd_wr, claim, addr_phase;
  logic                 drive, ad_drive, trdy, devsel, stop, mem_we;
  logic [31:0]          mem [DEPTH];

  // Accepted command set depends on whether the window lives in I/O or memory space
  always_comb begin
    cmd_rd = 1'b0;
    cmd_wr = 1'b0;
    if (MEM_SPACE != 0) begin
      cmd_rd = (PCI_CBE == 4'b0110) || (PCI_CBE == 4'b1100) || (PCI_CBE == 4'b1110);
      cmd_wr = (PCI_CBE == 4'b0111);
    end else begin
      cmd_rd = (PCI_CBE == 4'b0010);
      cmd_wr = (PCI_CBE == 4'b0011);
    end
  end

  assign addr_phase = !PCI_FRAMEn && bus_idle;
  assign claim      = (PCI_AD[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]) &&
                      (PCI_AD[1:0] == 2'b00) && (cmd_rd || cmd_wr);

  // Remember whether the previous cycle was bus idle, so a new FRAME# edge can be spotted
  always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
    if (!PCI_RSTn) bus_idle <= 1'b0;
    else           bus_idle <= PCI_FRAMEn && PCI_IRDYn;
  end

  // State, word pointer, stall counter and direction registers
  always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
    if (!PCI_RSTn) begin
      state   <= IDLE;
      ptr     <= '0;
      wcnt    <= 2'd0;
      is_read <= 1'b0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      wcnt    <= wcnt_d;
      is_read <= is_read_d;
    end
  end

  // Next-state decode plus handshake outputs; drive=0 leaves the target lines floating
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    wcnt_d    = wcnt;
    is_read_d = is_read;
    drive     = 1'b0;
    ad_drive  = 1'b0;
    trdy      = 1'b1;
    devsel    = 1'b1;
    stop      = 1'b1;
    mem_we    = 1'b0;
    unique case (state)
      IDLE: begin
        if (addr_phase) begin
          if (claim) begin
            ptr_d     = PCI_AD[ADDR_BITS+1:2];
            is_read_d = cmd_rd;
            wcnt_d    = 2'd0;
            if (cmd_rd)        state_d = TURN;
            else if (HAS_WAIT) state_d = WAIT;
            else               state_d = DATA;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (PCI_FRAMEn && PCI_IRDYn) state_d = IDLE;
      end
      TURN: begin
        drive   = 1'b1;
        devsel  = 1'b0;
        wcnt_d  = 2'd0;
        state_d = HAS_WAIT ? WAIT : DATA;
      end
      WAIT: begin
        drive    = 1'b1;
        devsel   = 1'b0;
        ad_drive = is_read;
        if (wcnt == WS_LAST) state_d = DATA;
        else                 wcnt_d  = wcnt + 2'd1;
      end
      DATA: begin
        drive    = 1'b1;
        devsel   = 1'b0;
        trdy     = 1'b0;
        ad_drive = is_read;
        stop     = !((ptr == LAST) && !PCI_FRAMEn);
        if (!PCI_IRDYn) begin
          mem_we = !is_read;
          if (PCI_FRAMEn) begin
            state_d = RELEASE;
          end else if (ptr == LAST) begin
            state_d = STOPPING;
          end else begin
            ptr_d   = ptr + ONE;
            wcnt_d  = 2'd0;
            state_d = HAS_WAIT ? WAIT : DATA;
          end
        end
      end
      STOPPING: begin
        drive  = 1'b1;
        devsel = 1'b0;
        stop   = 1'b0;
        if (PCI_FRAMEn) state_d = RELEASE;
      end
      RELEASE: begin
        drive   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte-lane write on each completed write data phase; contents survive reset
  always_ff @(posedge PCI_CLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (!PCI_CBE[b]) mem[ptr][8*b +: 8] <= PCI_AD[8*b +: 8];
      end
    end
  end

  assign PCI_AD      = ad_drive ? mem[ptr] : 32'bz;
  assign PCI_TRDYn   = drive ? trdy   : 1'bz;
  assign PCI_DEVSELn = drive ? devsel : 1'bz;
  assign PCI_STOPn   = drive ? stop   : 1'bz;

endmodule

// File: tb/tb_pci_target_mem.sv
// tb/tb_pci_target_mem.sv - scoreboard bench for pci_target_mem on two independent buses
module tb_pci_target_mem;

  localparam int WS0 = 0;
  localparam int WS1 = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        frame_v [2];
  logic        irdy_v  [2];
  logic [3:0]  cbe_v   [2];
  logic [31:0] ad_v    [2];
  logic        ad_oe   [2];
  bit          rd_act  [2];

  tri1 [31:0] ad0, ad1;
  tri1        trdy0, devsel0, stop0, trdy1, devsel1, stop1;

  assign ad0 = ad_oe[0] ? ad_v[0] : 32'bz;
  assign ad1 = ad_oe[1] ? ad_v[1] : 32'bz;

  always #5 clk = ~clk;

  pci_target_mem u_io (
    .PCI_CLK(clk), .PCI_RSTn(rstn), .PCI_FRAMEn(frame_v[0]), .PCI_IRDYn(irdy_v[0]),
    .PCI_CBE(cbe_v[0]), .PCI_AD(ad0), .PCI_TRDYn(trdy0), .PCI_DEVSELn(devsel0), .PCI_STOPn(stop0)
  );

  pci_target_mem #(.BASE_ADDR(32'h0000_1000), .ADDR_BITS(4), .MEM_SPACE(1), .WAIT_STATES(WS1)) u_mem (
    .PCI_CLK(clk), .PCI_RSTn(rstn), .PCI_FRAMEn(frame_v[1]), .PCI_IRDYn(irdy_v[1]),
    .PCI_CBE(cbe_v[1]), .PCI_AD(ad1), .PCI_TRDYn(trdy1), .PCI_DEVSELn(devsel1), .PCI_STOPn(stop1)
  );

  int          npass = 0;
  int          ntot  = 0;
  logic [31:0] model [2][16];
  logic [31:0] wd [16];
  logic [3:0]  wb [16];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  function automatic logic g_trdy(int d);   return d == 0 ? trdy0 : trdy1;     endfunction
  function automatic logic g_stop(int d);   return d == 0 ? stop0 : stop1;     endfunction
  function automatic logic g_devsel(int d); return d == 0 ? devsel0 : devsel1; endfunction
  function automatic logic [31:0] g_ad(int d); return d == 0 ? ad0 : ad1;      endfunction
  function automatic logic [31:0] ctl(int d);
    return {29'd0, g_trdy(d), g_devsel(d), g_stop(d)};
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (!be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Read-data monitor: pops the expected word whenever a read data phase completes
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rd_act[d] && irdy_v[d] == 1'b0 && g_trdy(d) === 1'b0) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            ntot++;
            $display("FAIL rdata%0d: got %h expected no read data", d, g_ad(d));
          end else if (d == 0) chk("rdata0", g_ad(0), q0.pop_front());
          else                 chk("rdata1", g_ad(1), q1.pop_front());
        end
      end
    end
  end

  task automatic xact(input int d, input int start, input bit rd, input int n);
    int ws, rem, acc, k, cyc;
    bit exp_stop, stopped, adv;
    logic [3:0] cmd;
    logic [31:0] base;
    ws   = (d == 0) ? WS0 : WS1;
    base = (d == 0) ? 32'h0000_0200 : 32'h0000_1000;
    if (!rd)      cmd = (d == 0) ? 4'b0011 : 4'b0111;
    else if (d == 0) cmd = 4'b0010;
    else case ($urandom_range(0, 2))
      0:       cmd = 4'b0110;
      1:       cmd = 4'b1100;
      default: cmd = 4'b1110;
    endcase
    rem      = 16 - start;
    acc      = (n <= rem) ? n : rem;
    exp_stop = (n > rem);
    for (int i = 0; i < acc; i++) begin
      if (rd) begin
        if (d == 0) q0.push_back(model[0][start+i]); else q1.push_back(model[1][start+i]);
      end else model[d][start+i] = merge(model[d][start+i], wd[i], wb[i]);
    end
    @(posedge clk); #1;
    frame_v[d] = 1'b0; ad_oe[d] = 1'b1; ad_v[d] = base + 32'(start * 4); cbe_v[d] = cmd;
    @(negedge clk);
    chk("addr_phase_float", ctl(d), 32'd7);
    @(posedge clk); #1;
    cyc = 1; k = 0; stopped = 1'b0;
    rd_act[d] = rd;
    if (rd) ad_oe[d] = 1'b0; else ad_v[d] = wd[0];
    cbe_v[d] = rd ? 4'b0000 : wb[0];
    irdy_v[d] = 1'b0;
    frame_v[d] = (n == 1);
    while (1) begin
      @(negedge clk);
      adv = 1'b0;
      if (cyc == 1) begin
        chk("devsel_cycle1", {31'd0, g_devsel(d)}, 32'd0);
        if (rd) chk("turn_ad_float", g_ad(d), 32'hFFFF_FFFF);
      end
      if (g_trdy(d) === 1'b0) begin
        chk("trdy_cycle", cyc, (rd ? 2 : 1) + ws + k * (1 + ws));
        if (g_stop(d) === 1'b0) stopped = 1'b1;
        k++;
        adv = 1'b1;
      end
      if (k == n || stopped || cyc >= 60) break;
      @(posedge clk); #1;
      cyc++;
      if (adv) begin
        if (!rd) begin ad_v[d] = wd[k]; cbe_v[d] = wb[k]; end
        frame_v[d] = (k == n - 1);
      end
    end
    if (cyc >= 60) begin
      ntot++;
      $display("FAIL timeout: got %0d phases expected %0d", k, acc);
    end
    chk("phases_accepted", k, acc);
    chk("disconnect", {31'd0, stopped}, {31'd0, exp_stop});
    @(posedge clk); #1;
    ad_oe[d] = 1'b0; cbe_v[d] = 4'b0000;
    if (stopped) begin
      frame_v[d] = 1'b1;
      @(negedge clk);
      chk("stopping", ctl(d), 32'd4);
      @(posedge clk); #1;
    end
    frame_v[d] = 1'b1; irdy_v[d] = 1'b1;
    @(negedge clk);
    chk("release", ctl(d), 32'd7);
    chk("release_ad_float", g_ad(d), 32'hFFFF_FFFF);
    rd_act[d] = 1'b0;
    chk("scoreboard_empty", d == 0 ? q0.size() : q1.size(), 32'd0);
    q0.delete(); q1.delete();
  endtask

  task automatic nonclaim(input int d, input logic [31:0] addr, input logic [3:0] cmd);
    logic ok;
    ok = 1'b1;
    @(posedge clk); #1;
    frame_v[d] = 1'b0; ad_oe[d] = 1'b1; ad_v[d] = addr; cbe_v[d] = cmd;
    @(negedge clk); ok &= (ctl(d) === 32'd7);
    @(posedge clk); #1; ad_oe[d] = 1'b0; irdy_v[d] = 1'b0; cbe_v[d] = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); ok &= (ctl(d) === 32'd7) && (g_ad(d) === 32'hFFFF_FFFF);
      @(posedge clk); #1;
      if (i == 1) frame_v[d] = 1'b1;
      if (i == 2) irdy_v[d] = 1'b1;
    end
    @(negedge clk); ok &= (ctl(d) === 32'd7) && (g_ad(d) === 32'hFFFF_FFFF);
    chk($sformatf("nonclaim_%h_%b", addr, cmd), {31'd0, ok}, 32'd1);
  endtask

  task automatic fill_rand(input bit full_be);
    for (int i = 0; i < 16; i++) begin
      wd[i] = $urandom;
      wb[i] = full_be ? 4'b0000 : 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      frame_v[d] = 1'b1; irdy_v[d] = 1'b1; cbe_v[d] = 4'b0000;
      ad_v[d] = 32'd0; ad_oe[d] = 1'b0; rd_act[d] = 1'b0;
    end
    @(negedge clk);
    chk("reset_ctl_io", ctl(0), 32'd7);
    chk("reset_ctl_mem", ctl(1), 32'd7);
    chk("reset_ad_io", g_ad(0), 32'hFFFF_FFFF);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    fill_rand(1'b1); xact(0, 0, 1'b0, 16);
    fill_rand(1'b1); xact(1, 0, 1'b0, 16);

    wd[0] = 32'hDEAD_BEEF; wb[0] = 4'b0000;
    xact(0, 2, 1'b0, 1);
    xact(0, 2, 1'b1, 1);

    wd[0] = 32'hAABB_CCDD; wb[0] = 4'b0000; xact(0, 3, 1'b0, 1);
    wd[0] = 32'h1122_3344; wb[0] = 4'b1010; xact(0, 3, 1'b0, 1);
    xact(0, 3, 1'b1, 1);

    fill_rand(1'b1); xact(1, 14, 1'b0, 4);
    xact(1, 14, 1'b1, 2);
    xact(1, 0, 1'b1, 2);

    nonclaim(0, 32'h0000_0240, 4'b0010);
    nonclaim(0, 32'h0000_0202, 4'b0010);
    nonclaim(0, 32'h0000_0208, 4'b0110);
    nonclaim(1, 32'h0000_1000, 4'b0010);

    fill_rand(1'b1);
    @(posedge clk); #1;
    frame_v[0] = 1'b0; ad_oe[0] = 1'b1; ad_v[0] = 32'h0000_0200; cbe_v[0] = 4'b0011;
    @(posedge clk); #1;
    ad_v[0] = wd[0]; cbe_v[0] = 4'b0000; irdy_v[0] = 1'b0;
    @(posedge clk); #1;
    ad_v[0] = wd[1];
    rstn = 1'b0;
    #1;
    chk("reset_mid_burst_float", ctl(0), 32'd7);
    frame_v[0] = 1'b1; irdy_v[0] = 1'b1; ad_oe[0] = 1'b0;
    model[0][0] = wd[0];
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);
    xact(0, 0, 1'b1, 2);

    for (int t = 0; t < 40; t++) begin
      int d, s, n;
      bit rd;
      d  = $urandom_range(0, 1);
      s  = $urandom_range(0, 15);
      n  = $urandom_range(1, 4);
      rd = $urandom_range(0, 1);
      fill_rand(1'b0);
      xact(d, s, rd, n);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
